// File: rtl/wb_slv_pkg.sv
// Shared types for the Wishbone register responder.
// FSM state and response-type encodings plus a byte-lane merge helper.
package wb_slv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP,
        ST_DONE
    } state_t;

    typedef enum logic [1:0] {
        RSP_ACK,
        RSP_ERR,
        RSP_RTY
    } resp_t;

    localparam int DATA_W = 32;
    localparam int SEL_W  = 4;

    function automatic logic [DATA_W-1:0] lane_merge(
        input logic [DATA_W-1:0] old_w,
        input logic [DATA_W-1:0] new_w,
        input logic [SEL_W-1:0]  sel
    );
        lane_merge = old_w;
        for (int b = 0; b < SEL_W; b++) begin
            if (sel[b]) begin
                lane_merge[8*b +: 8] = new_w[8*b +: 8];
            end
        end
    endfunction

endpackage

// File: rtl/wb_slv_regfile.sv
// Storage words of the register responder.
// Byte-lane synchronous write, combinational read.
module wb_slv_regfile
    import wb_slv_pkg::*;
#(
    parameter int          IDX_W   = 3,
    parameter int          NWORDS  = 7,
    parameter logic [31:0] RST_VAL = 32'h0
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_widx,
    input  logic [SEL_W-1:0]  i_sel,
    input  logic [DATA_W-1:0] i_wdat,
    input  logic [IDX_W-1:0]  i_ridx,
    output logic [DATA_W-1:0] o_rdat
);

    logic [DATA_W-1:0] r_mem [NWORDS];

    always_ff @(posedge clk) begin
        if (i_rst) begin
            for (int w = 0; w < NWORDS; w++) begin
                r_mem[w] <= RST_VAL;
            end
        end else if (i_we) begin
            for (int w = 0; w < NWORDS; w++) begin
                if (i_widx == IDX_W'(w)) begin
                    r_mem[w] <= lane_merge(r_mem[w], i_wdat, i_sel);
                end
            end
        end
    end

    always_comb begin
        o_rdat = '0;
        for (int w = 0; w < NWORDS; w++) begin
            if (i_ridx == IDX_W'(w)) begin
                o_rdat = r_mem[w];
            end
        end
    end

endmodule

// File: rtl/wb_slv_regs.sv
// Wishbone classic register responder with wait states, retry and an
// access counter in the top word.
module wb_slv_regs
    import wb_slv_pkg::*;
#(
    parameter int          ADDR_W      = 5,
    parameter int          DEPTH       = 8,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] RST_VAL     = 32'h0
) (
    input  logic              clk,
    input  logic              wb_rst_i,
    input  logic [ADDR_W-1:0] wb_adr_i,
    input  logic [31:0]       wb_dat_i,
    output logic [31:0]       wb_dat_o,
    input  logic              wb_we_i,
    input  logic              wb_stb_i,
    input  logic              wb_cyc_i,
    input  logic [3:0]        wb_sel_i,
    output logic              wb_ack_o,
    output logic              wb_err_o,
    output logic              wb_rty_o,
    input  logic              busy_i
);

    localparam int IDX_W = ADDR_W - 2;
    localparam logic [3:0] WCNT_INIT =
        4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam bit NO_WAIT = (WAIT_STATES == 0);

    state_t            r_state;
    resp_t             r_resp;
    logic [3:0]        r_wcnt;
    logic [IDX_W-1:0]  r_idx;
    logic [31:0]       r_wdat;
    logic [3:0]        r_sel;
    logic              r_we;
    logic              r_ack;
    logic              r_err;
    logic              r_rty;
    logic [31:0]       r_dat_o;
    logic [31:0]       r_cnt;

    logic              w_req;
    logic [IDX_W-1:0]  w_bus_idx;
    logic [IDX_W-1:0]  w_rd_idx;
    logic              w_oob;
    logic              w_cnt_hit;
    logic              w_rd_we;
    logic [31:0]       w_rf_rdat;
    logic [31:0]       w_rd_data;
    logic              w_rf_we;
    logic              w_enter_resp;
    resp_t             w_new_resp;
    resp_t             w_ent_resp;
    logic              w_unused_adr;

    assign w_unused_adr = ^wb_adr_i[1:0];

    assign w_req     = wb_cyc_i & wb_stb_i;
    assign w_bus_idx = wb_adr_i[ADDR_W-1:2];

    // Until acceptance the live bus selects the word; afterwards the latch.
    assign w_rd_idx  = (r_state == ST_IDLE) ? w_bus_idx : r_idx;
    assign w_rd_we   = (r_state == ST_IDLE) ? wb_we_i : r_we;
    assign w_oob     = 32'(w_bus_idx) >= 32'(DEPTH);
    assign w_cnt_hit = 32'(w_rd_idx) == 32'(DEPTH - 1);
    assign w_rd_data = w_cnt_hit ? r_cnt : w_rf_rdat;

    assign w_rf_we = (r_state == ST_RESP) && (r_resp == RSP_ACK)
                  && r_we && !w_cnt_hit;

    always_comb begin
        w_new_resp = RSP_ACK;
        if (busy_i) begin
            w_new_resp = RSP_RTY;
        end else if (w_oob) begin
            w_new_resp = RSP_ERR;
        end
    end

    always_comb begin
        w_enter_resp = 1'b0;
        w_ent_resp   = r_resp;
        unique case (r_state)
            ST_IDLE: begin
                w_enter_resp = w_req & (busy_i | NO_WAIT);
                w_ent_resp   = w_new_resp;
            end
            ST_WAIT: w_enter_resp = w_req & (r_wcnt == 4'd0);
            default: w_enter_resp = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
            r_resp  <= RSP_ACK;
            r_wcnt  <= '0;
            r_idx   <= '0;
            r_wdat  <= '0;
            r_sel   <= '0;
            r_we    <= 1'b0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rty   <= 1'b0;
            r_dat_o <= '0;
            r_cnt   <= '0;
        end else begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rty   <= 1'b0;
            r_dat_o <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_idx  <= w_bus_idx;
                        r_wdat <= wb_dat_i;
                        r_we   <= wb_we_i;
                        r_sel  <= wb_sel_i;
                        r_resp <= w_new_resp;
                        r_wcnt <= WCNT_INIT;
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!w_req) begin
                        r_state <= ST_IDLE;
                    end else if (r_wcnt != 4'd0) begin
                        r_wcnt <= r_wcnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_DONE;
                    if (r_resp == RSP_ACK) begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                ST_DONE: begin
                    if (!w_req) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            // Response flags are launched as the FSM enters RESP.
            if (w_enter_resp) begin
                r_state <= ST_RESP;
                r_ack   <= (w_ent_resp == RSP_ACK);
                r_err   <= (w_ent_resp == RSP_ERR);
                r_rty   <= (w_ent_resp == RSP_RTY);
                if (w_ent_resp == RSP_ACK && !w_rd_we) begin
                    r_dat_o <= w_rd_data;
                end
            end
        end
    end

    wb_slv_regfile #(
        .IDX_W   (IDX_W),
        .NWORDS  (DEPTH - 1),
        .RST_VAL (RST_VAL)
    ) u_regfile (
        .clk    (clk),
        .i_rst  (wb_rst_i),
        .i_we   (w_rf_we),
        .i_widx (r_idx),
        .i_sel  (r_sel),
        .i_wdat (r_wdat),
        .i_ridx (w_rd_idx),
        .o_rdat (w_rf_rdat)
    );

    assign wb_ack_o = r_ack;
    assign wb_err_o = r_err;
    assign wb_rty_o = r_rty;
    assign wb_dat_o = r_dat_o;

endmodule

// File: tb/tb_wb_slv_regs.sv
// Scoreboard bench for wb_slv_regs: a zero-wait instance (DEPTH=8)
// and a three-wait instance (DEPTH=4).
module tb_wb_slv_regs;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] dat;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst  [2];
    logic [4:0]  adr  [2];
    logic [31:0] dati [2];
    logic [31:0] dato [2];
    logic        we   [2];
    logic        stb  [2];
    logic        cyc  [2];
    logic [3:0]  sel  [2];
    logic        ack  [2];
    logic        err  [2];
    logic        rty  [2];
    logic        busy [2];

    exp_t        q0[$];
    exp_t        q1[$];
    logic [31:0] mdl  [2][8];
    logic [31:0] mcnt [2];
    int          cyc_n = 0;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n++;

    wb_slv_regs u_dut0 (
        .clk(clk), .wb_rst_i(rst[0]), .wb_adr_i(adr[0]),
        .wb_dat_i(dati[0]), .wb_dat_o(dato[0]), .wb_we_i(we[0]),
        .wb_stb_i(stb[0]), .wb_cyc_i(cyc[0]), .wb_sel_i(sel[0]),
        .wb_ack_o(ack[0]), .wb_err_o(err[0]), .wb_rty_o(rty[0]),
        .busy_i(busy[0])
    );

    wb_slv_regs #(.DEPTH(4), .WAIT_STATES(3)) u_dut1 (
        .clk(clk), .wb_rst_i(rst[1]), .wb_adr_i(adr[1]),
        .wb_dat_i(dati[1]), .wb_dat_o(dato[1]), .wb_we_i(we[1]),
        .wb_stb_i(stb[1]), .wb_cyc_i(cyc[1]), .wb_sel_i(sel[1]),
        .wb_ack_o(ack[1]), .wb_err_o(err[1]), .wb_rty_o(rty[1]),
        .busy_i(busy[1])
    );

    task automatic check(string tag, logic [31:0] act,
                         logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h @cyc %0d",
                     tag, act, exp, cyc_n);
        end
    endtask

    task automatic mon(int i);
        exp_t e;
        logic [1:0] k;
        bit empty;
        if (ack[i] | err[i] | rty[i]) begin
            k = ack[i] ? 2'd0 : (err[i] ? 2'd1 : 2'd2);
            check($sformatf("onehot%0d", i),
                  32'(ack[i]) + 32'(err[i]) + 32'(rty[i]), 1);
            empty = (i == 0) ? (q0.size() == 0) : (q1.size() == 0);
            if (empty) begin
                check($sformatf("spurious%0d", i), 1, 0);
            end else begin
                if (i == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                check($sformatf("kind%0d", i), 32'(k), 32'(e.kind));
                check($sformatf("dat%0d", i), dato[i], e.dat);
                check($sformatf("lat%0d", i), cyc_n, e.due);
            end
        end else begin
            check($sformatf("dat_idle%0d", i), dato[i], 0);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) mon(i);
    end

    task automatic mdl_reset(int i);
        for (int w = 0; w < 8; w++) mdl[i][w] = 32'h0;
        mcnt[i] = 32'h0;
    endtask

    task automatic drive(int i, bit w, logic [4:0] a,
                         logic [31:0] d, logic [3:0] s, bit bz);
        adr[i]  = a;
        dati[i] = d;
        we[i]   = w;
        sel[i]  = s;
        busy[i] = bz;
        cyc[i]  = 1'b1;
        stb[i]  = 1'b1;
    endtask

    task automatic idle_bus(int i);
        cyc[i]  = 1'b0;
        stb[i]  = 1'b0;
        busy[i] = 1'b0;
    endtask

    // Full access: predict, push, drive, wait bounded, release.
    task automatic bus(int i, bit w, logic [4:0] a, logic [31:0] d,
                       logic [3:0] s, bit bz, int hold, bit bz_mid);
        int   ws    = (i == 0) ? 0 : 3;
        int   depth = (i == 0) ? 8 : 4;
        int   idx   = int'(a[4:2]);
        exp_t e;
        bit   done;
        e.kind = bz ? 2'd2 : ((idx >= depth) ? 2'd1 : 2'd0);
        e.dat  = 32'h0;
        if (e.kind == 2'd0 && !w)
            e.dat = (idx == depth - 1) ? mcnt[i] : mdl[i][idx];
        if (e.kind == 2'd0) begin
            if (w && idx < depth - 1)
                for (int b = 0; b < 4; b++)
                    if (s[b]) mdl[i][idx][8*b +: 8] = d[8*b +: 8];
            mcnt[i] = mcnt[i] + 32'd1;
        end
        e.due = cyc_n + 1 + ((e.kind == 2'd2) ? 0 : ws);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
        drive(i, w, a, d, s, bz);
        done = 1'b0;
        for (int t = 0; t < 30 && !done; t++) begin
            @(negedge clk);
            done = ack[i] | err[i] | rty[i];
            adr[i]  = 5'($urandom);
            dati[i] = $urandom;
            we[i]   = ~w;
            sel[i]  = 4'($urandom);
            if (bz_mid) busy[i] = 1'b1;
        end
        if (!done) begin
            check($sformatf("timeout%0d", i), 0, 1);
            if (i == 0) void'(q0.pop_back());
            else        void'(q1.pop_back());
        end
        repeat (hold) @(negedge clk);
        idle_bus(i);
        repeat (2) @(negedge clk);
    endtask

    task automatic abort_wr(int i, logic [4:0] a, logic [31:0] d);
        drive(i, 1'b1, a, d, 4'hF, 1'b0);
        @(negedge clk);
        idle_bus(i);
        repeat (6) @(negedge clk);
    endtask

    task automatic pulse_reset(int i);
        rst[i] = 1'b1;
        idle_bus(i);
        repeat (2) @(negedge clk);
        rst[i] = 1'b0;
        mdl_reset(i);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1;
            adr[i] = '0;
            dati[i] = '0;
            we[i] = 1'b0;
            sel[i] = '0;
            idle_bus(i);
            mdl_reset(i);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_ack", 32'(ack[i]), 0);
            check("rst_err", 32'(err[i]), 0);
            check("rst_rty", 32'(rty[i]), 0);
            check("rst_dat", dato[i], 0);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;

        // Zero-wait instance, first access right after reset.
        bus(0, 1, 5'h04, 32'hA5A5_1234, 4'hF, 0, 0, 0);
        bus(0, 0, 5'h04, 32'h0, 4'hF, 0, 0, 0);
        pulse_reset(0);
        bus(0, 0, 5'h04, 32'h0, 4'hF, 0, 0, 0);
        bus(0, 0, 5'h00, 32'h0, 4'hF, 1, 0, 0);
        bus(0, 0, 5'h00, 32'h0, 4'hF, 0, 0, 0);
        bus(0, 0, 5'h1C, 32'h0, 4'hF, 0, 0, 0);
        bus(0, 1, 5'h08, 32'h1122_3344, 4'b1010, 0, 0, 0);
        bus(0, 0, 5'h08, 32'h0, 4'hF, 0, 0, 0);
        bus(0, 1, 5'h08, 32'hDEAD_BEEF, 4'b0000, 0, 0, 0);
        bus(0, 0, 5'h08, 32'h0, 4'hF, 0, 0, 0);
        bus(0, 1, 5'h1C, 32'h5555_5555, 4'hF, 0, 0, 0);
        bus(0, 1, 5'h18, 32'hCAFE_F00D, 4'b0011, 0, 0, 0);
        bus(0, 0, 5'h18, 32'h0, 4'hF, 0, 5, 0);
        bus(0, 0, 5'h1C, 32'h0, 4'hF, 0, 0, 0);

        // Three-wait instance with DEPTH=4.
        bus(1, 1, 5'h00, 32'hFFFF_FFFF, 4'b0101, 0, 0, 0);
        bus(1, 0, 5'h00, 32'h0, 4'hF, 0, 0, 0);
        bus(1, 0, 5'h1C, 32'h0, 4'hF, 0, 0, 0);
        bus(1, 1, 5'h10, 32'h1234_5678, 4'hF, 0, 0, 0);
        bus(1, 0, 5'h0C, 32'h0, 4'hF, 0, 0, 0);
        abort_wr(1, 5'h04, 32'h1234_5678);
        bus(1, 0, 5'h04, 32'h0, 4'hF, 0, 0, 0);
        bus(1, 0, 5'h00, 32'h0, 4'hF, 1, 0, 0);
        bus(1, 0, 5'h00, 32'h0, 4'hF, 0, 0, 1);
        bus(1, 1, 5'h08, 32'h0BAD_F00D, 4'hF, 0, 3, 0);
        bus(1, 0, 5'h08, 32'h0, 4'hF, 0, 0, 0);
        bus(1, 0, 5'h0C, 32'h0, 4'hF, 0, 0, 0);

        // Reset while a write sits in WAIT.
        drive(1, 1'b1, 5'h08, 32'h7777_7777, 4'hF, 1'b0);
        @(negedge clk);
        pulse_reset(1);
        bus(1, 0, 5'h08, 32'h0, 4'hF, 0, 0, 0);
        bus(1, 0, 5'h0C, 32'h0, 4'hF, 0, 0, 0);

        repeat (4) @(negedge clk);
        check("sb_empty", 32'(q0.size() + q1.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
